// File: rtl/mor1kx_immu_walker_pkg.sv
// Shared definitions for the IMMU/DMMU table walkers: PTE bit positions and
// walker state encodings.
package mor1kx_immu_walker_pkg;

  localparam int PTE_PRESENT = 10;
  localparam int PTE_L       = 9;
  localparam int PTE_X       = 8;
  localparam int PTE_W       = 7;
  localparam int PTE_U       = 6;

  typedef enum logic [2:0] {
    WS_IDLE   = 3'd0,
    WS_L1     = 3'd1,
    WS_L2     = 3'd2,
    WS_VICTIM = 3'd3,
    WS_WRITE  = 3'd4,
    WS_SETTLE = 3'd5,
    WS_ABORT  = 3'd6
  } walker_state_t;

endpackage

// File: rtl/mor1kx_tlb_victim.sv
// TLB victim selection: lowest invalid way first, otherwise a per-set
// round-robin pointer that only advances when every way was valid.
module mor1kx_tlb_victim #(
  parameter int SET_W = 6,
  parameter int WAYS  = 2,
  localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] set_i,
  input  logic [WAYS-1:0]  way_valid_i,
  input  logic             update_i,
  output logic [IDX_W-1:0] victim_o
);

  generate
    if (WAYS == 1) begin : g_single
      logic unused_single;
      assign unused_single = ^{clk, rst, set_i, way_valid_i, update_i};
      assign victim_o = '0;
    end else begin : g_multi
      logic [IDX_W-1:0] rr [2**SET_W];
      logic [IDX_W-1:0] first_free;
      logic             any_free;

      // Descending scan so the lowest invalid way is the one that sticks.
      always_comb begin
        first_free = '0;
        any_free   = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
          if (!way_valid_i[i]) begin
            first_free = IDX_W'(i);
            any_free   = 1'b1;
          end
        end
      end

      assign victim_o = any_free ? first_free : rr[set_i];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < 2**SET_W; s++) rr[s] <= '0;
        end else if (update_i && !any_free) begin
          rr[set_i] <= (rr[set_i] == IDX_W'(WAYS - 1)) ? '0 : rr[set_i] + IDX_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mor1kx_immu_walker.sv
// Hardware ITLB reload: two-level page-table walk on a miss, then a
// single-cycle fill of the chosen victim way.
module mor1kx_immu_walker
  import mor1kx_immu_walker_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH  = 32,
  parameter int OPTION_IMMU_SET_WIDTH = 6,
  parameter int OPTION_IMMU_WAYS      = 2,
  parameter int OPTION_PAGE_BITS      = 13,
  parameter int OPTION_HUGE_BITS      = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable_i,
  input  logic                             miss_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  miss_vaddr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  ptbr_i,
  input  logic                             flush_i,
  output logic                             busy_o,
  output logic                             req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  addr_o,
  input  logic                             ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  data_i,
  output logic                             pagefault_o,
  input  logic                             pagefault_clear_i,
  output logic [OPTION_IMMU_SET_WIDTH-1:0] fill_set_o,
  input  logic [OPTION_IMMU_WAYS-1:0]      way_valid_i,
  output logic [OPTION_IMMU_WAYS-1:0]      fill_we_o,
  output logic                             fill_huge_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  fill_match_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  fill_trans_o,
  output walker_state_t                    dbg_state_o
);

  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int SET_W = OPTION_IMMU_SET_WIDTH;
  localparam int WAYS  = OPTION_IMMU_WAYS;
  localparam int PAGE  = OPTION_PAGE_BITS;
  localparam int HUGE  = OPTION_HUGE_BITS;
  localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAYS-1:0] WAY_ONE = WAYS'(1);

  // Handshake: req_o/addr_o are registered and held until the cycle ack_i is
  // seen high; that cycle data_i is consumed and the request ends or moves on.
  walker_state_t    state;
  logic [W-1:0]     va;
  logic             do_walk;
  logic             fill_en;
  logic             l1_bad;
  logic             leaf_load;
  logic             leaf_huge;
  logic [7:0]       leaf_flags;
  logic [SET_W-1:0] leaf_set;
  logic [W-1:0]     leaf_match;
  logic [W-1:0]     leaf_trans;
  logic [IDX_W-1:0] victim;
  logic             unused_bits;

  assign unused_bits = ^{ptbr_i[W-HUGE+1:0], va[PAGE-1:0],
                         data_i[PAGE-1:PTE_PRESENT+1], data_i[PTE_W]};

  assign do_walk = enable_i & miss_i & (|ptbr_i[W-1:W-HUGE+2]) & ~pagefault_o &
                   (state == WS_IDLE) & ~flush_i;
  assign busy_o  = do_walk | (state != WS_IDLE);
  assign dbg_state_o = state;

  // A leaf found at level 1 is by definition a huge page.
  assign l1_bad    = (data_i[W-1:PAGE] == '0) | (data_i[PTE_L] & ~data_i[PTE_PRESENT]);
  assign leaf_load = ack_i & ~flush_i &
                     (((state == WS_L1) & ~l1_bad & data_i[PTE_L]) |
                      ((state == WS_L2) & data_i[PTE_PRESENT]));
  assign leaf_huge  = (state == WS_L1);
  assign leaf_flags = {data_i[PTE_X] & data_i[PTE_U], data_i[PTE_X], data_i[5:0]};

  always_comb begin
    if (leaf_huge) begin
      leaf_set   = va[HUGE+SET_W-1:HUGE];
      leaf_match = {va[W-1:HUGE], {(HUGE-2){1'b0}}, 2'b11};
      leaf_trans = {data_i[W-1:HUGE], {(HUGE-8){1'b0}}, leaf_flags};
    end else begin
      leaf_set   = va[PAGE+SET_W-1:PAGE];
      leaf_match = {va[W-1:PAGE], {(PAGE-2){1'b0}}, 2'b01};
      leaf_trans = {data_i[W-1:PAGE], {(PAGE-8){1'b0}}, leaf_flags};
    end
  end

  assign fill_en   = (state == WS_WRITE) & ~flush_i;
  assign fill_we_o = fill_en ? (WAY_ONE << victim) : '0;

  mor1kx_tlb_victim #(
    .SET_W (SET_W),
    .WAYS  (WAYS)
  ) u_victim (
    .clk         (clk),
    .rst         (rst),
    .set_i       (fill_set_o),
    .way_valid_i (way_valid_i),
    .update_i    (fill_en),
    .victim_o    (victim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_set_o   <= '0;
      fill_huge_o  <= 1'b0;
      fill_match_o <= '0;
      fill_trans_o <= '0;
    end else if (leaf_load) begin
      fill_set_o   <= leaf_set;
      fill_huge_o  <= leaf_huge;
      fill_match_o <= leaf_match;
      fill_trans_o <= leaf_trans;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WS_IDLE;
      va          <= '0;
      req_o       <= 1'b0;
      addr_o      <= '0;
      pagefault_o <= 1'b0;
    end else begin
      if (pagefault_clear_i) pagefault_o <= 1'b0;
      case (state)
        WS_IDLE: begin
          if (do_walk) begin
            state  <= WS_L1;
            va     <= miss_vaddr_i;
            req_o  <= 1'b1;
            addr_o <= {ptbr_i[W-1:W-HUGE+2], miss_vaddr_i[W-1:HUGE], 2'b00};
          end
        end
        WS_L1: begin
          if (ack_i) begin
            if (flush_i) begin
              req_o <= 1'b0;
              state <= WS_IDLE;
            end else if (l1_bad) begin
              pagefault_o <= 1'b1;
              req_o       <= 1'b0;
              state       <= WS_IDLE;
            end else if (data_i[PTE_L]) begin
              req_o <= 1'b0;
              state <= WS_VICTIM;
            end else begin
              addr_o <= {data_i[W-1:PAGE], va[HUGE-1:PAGE], 2'b00};
              state  <= WS_L2;
            end
          end else if (flush_i) begin
            state <= WS_ABORT;
          end
        end
        WS_L2: begin
          if (ack_i) begin
            req_o <= 1'b0;
            if (flush_i) begin
              state <= WS_IDLE;
            end else if (!data_i[PTE_PRESENT]) begin
              pagefault_o <= 1'b1;
              state       <= WS_IDLE;
            end else begin
              state <= WS_VICTIM;
            end
          end else if (flush_i) begin
            state <= WS_ABORT;
          end
        end
        WS_VICTIM: state <= flush_i ? WS_IDLE : WS_WRITE;
        WS_WRITE:  state <= flush_i ? WS_IDLE : WS_SETTLE;
        WS_SETTLE: state <= WS_IDLE;
        WS_ABORT: begin
          if (ack_i) begin
            req_o <= 1'b0;
            state <= WS_IDLE;
          end
        end
        default: state <= WS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_immu_walker.sv
// Bench for mor1kx_immu_walker: table of miss walks plus hand sequences for
// faults, flushes and asynchronous reset.
module tb_mor1kx_immu_walker;
  import mor1kx_immu_walker_pkg::*;

  localparam int W     = 32;
  localparam int SET_W = 6;
  localparam int WAYS  = 2;
  localparam int FW    = WAYS + SET_W + 1 + 2 * W;

  typedef struct {
    logic [31:0] va;
    logic [31:0] l1;
    logic [31:0] l2;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic        fault;
    int          lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable_i, miss_i, flush_i, ack_i, pagefault_clear_i;
  logic [W-1:0]     miss_vaddr_i, ptbr_i, data_i;
  logic [WAYS-1:0]  way_valid_i;
  logic             busy_o, req_o, pagefault_o, fill_huge_o;
  logic [W-1:0]     addr_o, fill_match_o, fill_trans_o;
  logic [SET_W-1:0] fill_set_o;
  logic [WAYS-1:0]  fill_we_o;
  walker_state_t    dbg_state_o;

  logic [FW-1:0] exp_q[$];
  logic [W-1:0]  addr_q[$];

  int n_vec = 0;
  int n_err = 0;
  int ack_delay, wait_cnt, acks;
  logic [31:0] cur_l1, cur_l2;
  logic [1:0]  cur_valid;

  localparam logic [31:0] PTBR = 32'h0010_0000;

  mor1kx_immu_walker #(
    .OPTION_OPERAND_WIDTH  (32),
    .OPTION_IMMU_SET_WIDTH (6),
    .OPTION_IMMU_WAYS      (2),
    .OPTION_PAGE_BITS      (13),
    .OPTION_HUGE_BITS      (24)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable_i          (enable_i),
    .miss_i            (miss_i),
    .miss_vaddr_i      (miss_vaddr_i),
    .ptbr_i            (ptbr_i),
    .flush_i           (flush_i),
    .busy_o            (busy_o),
    .req_o             (req_o),
    .addr_o            (addr_o),
    .ack_i             (ack_i),
    .data_i            (data_i),
    .pagefault_o       (pagefault_o),
    .pagefault_clear_i (pagefault_clear_i),
    .fill_set_o        (fill_set_o),
    .way_valid_i       (way_valid_i),
    .fill_we_o         (fill_we_o),
    .fill_huge_o       (fill_huge_o),
    .fill_match_o      (fill_match_o),
    .fill_trans_o      (fill_trans_o),
    .dbg_state_o       (dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [31:0] m_l1_addr(input logic [31:0] va);
    return {PTBR[31:10], va[31:24], 2'b00};
  endfunction

  function automatic logic [31:0] m_l2_addr(input logic [31:0] l1, input logic [31:0] va);
    return {l1[31:13], va[23:13], 2'b00};
  endfunction

  function automatic logic [FW-1:0] m_fill(input vec_t v);
    logic        huge;
    logic [31:0] leaf, m, t;
    logic [5:0]  set;
    logic [7:0]  fl;
    huge = v.l1[9];
    leaf = huge ? v.l1 : v.l2;
    fl   = {leaf[8] & leaf[6], leaf[8], leaf[5:0]};
    if (huge) begin
      set = v.va[29:24];
      m   = {v.va[31:24], 22'h0, 2'b11};
      t   = {leaf[31:24], 16'h0, fl};
    end else begin
      set = v.va[18:13];
      m   = {v.va[31:13], 11'h0, 2'b01};
      t   = {leaf[31:13], 5'h0, fl};
    end
    return {v.we, set, huge, m, t};
  endfunction

  // Driver: one cycle from negedge to negedge, with the bus/RAM responder.
  task automatic step(output logic busy_s);
    if (req_o) begin
      if (addr_q.size() == 0) fail_now("bus_unexp");
      else check("bus_addr", addr_o, addr_q[0]);
      if (wait_cnt >= ack_delay) begin
        ack_i    = 1'b1;
        data_i   = (acks == 0) ? cur_l1 : cur_l2;
        acks++;
        wait_cnt = 0;
        if (addr_q.size() != 0) void'(addr_q.pop_front());
      end else begin
        ack_i  = 1'b0;
        data_i = '0;
        wait_cnt++;
      end
    end else begin
      ack_i  = 1'b0;
      data_i = '0;
    end
    way_valid_i = cur_valid;
    #1;
    busy_s = busy_o;
    if (fill_we_o != '0) begin
      if (exp_q.size() == 0) fail_now("fill_unexp");
      else check("fill", {fill_we_o, fill_set_o, fill_huge_o, fill_match_o, fill_trans_o},
                 exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_walk(input vec_t v, input int flush_at, input int clr_at, input int delay);
    logic l1_ok, leaf_ok, b;
    int   n;
    l1_ok   = (v.l1[31:13] != '0) && !(v.l1[9] && !v.l1[10]);
    leaf_ok = l1_ok && (v.l1[9] || v.l2[10]);
    addr_q.push_back(m_l1_addr(v.va));
    if (l1_ok && !v.l1[9] && (flush_at < 0 || flush_at >= 2))
      addr_q.push_back(m_l2_addr(v.l1, v.va));
    if (leaf_ok && flush_at < 0) exp_q.push_back(m_fill(v));
    cur_l1 = v.l1; cur_l2 = v.l2; cur_valid = v.valid;
    acks = 0; wait_cnt = 0; ack_delay = delay;
    miss_i = 1'b1; miss_vaddr_i = v.va;
    n = 0; b = 1'b1;
    while (b && n < 64) begin
      flush_i = (n == flush_at);
      pagefault_clear_i = (n == clr_at);
      step(b);
      miss_i = 1'b0;
      n++;
    end
    flush_i = 1'b0; pagefault_clear_i = 1'b0;
    if (b) fail_now("walk_timeout");
    if (v.lat >= 0) check("latency", n - 1, v.lat);
    check("pagefault", pagefault_o, v.fault);
    check("bus_reads_left", addr_q.size(), 0);
    check("fills_left", exp_q.size(), 0);
    addr_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_fault();
    logic b;
    pagefault_clear_i = 1'b1;
    step(b);
    pagefault_clear_i = 1'b0;
    check("fault_cleared", pagefault_o, 1'b0);
  endtask

  vec_t vecs[12];
  vec_t v;
  logic b;

  initial begin
    vecs[0]  = '{va: 32'h0040_2000, l1: 32'h1234_6000, l2: 32'h5678_A5C7, valid: 2'b00, we: 2'b01, fault: 1'b0, lat: 6};
    vecs[1]  = '{va: 32'h3F00_0000, l1: 32'h8000_0740, l2: 32'h0,         valid: 2'b01, we: 2'b10, fault: 1'b0, lat: 5};
    vecs[2]  = '{va: 32'h0012_4000, l1: 32'h0ABC_E000, l2: 32'h0DEF_0400, valid: 2'b10, we: 2'b01, fault: 1'b0, lat: 6};
    vecs[3]  = '{va: 32'h0000_A000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b01, fault: 1'b0, lat: 6};
    vecs[4]  = '{va: 32'h0100_A000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b10, fault: 1'b0, lat: 6};
    vecs[5]  = '{va: 32'h0200_A000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b01, fault: 1'b0, lat: 6};
    vecs[6]  = '{va: 32'h0300_A000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b10, fault: 1'b0, lat: 6};
    vecs[7]  = '{va: 32'h0000_C000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b01, fault: 1'b0, lat: 6};
    vecs[8]  = '{va: 32'h0400_A000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b01, fault: 1'b0, lat: 6};
    vecs[9]  = '{va: 32'h0040_2000, l1: 32'h0000_1FFF, l2: 32'h0,         valid: 2'b00, we: 2'b00, fault: 1'b1, lat: 2};
    vecs[10] = '{va: 32'h0500_0000, l1: 32'h8000_0200, l2: 32'h0,         valid: 2'b00, we: 2'b00, fault: 1'b1, lat: 2};
    vecs[11] = '{va: 32'h0040_2000, l1: 32'h1234_6000, l2: 32'h1111_1000, valid: 2'b00, we: 2'b00, fault: 1'b1, lat: 3};

    rst = 1'b1; enable_i = 1'b1; miss_i = 1'b0; flush_i = 1'b0; ack_i = 1'b0;
    pagefault_clear_i = 1'b0; miss_vaddr_i = '0; ptbr_i = PTBR; data_i = '0;
    way_valid_i = '0; cur_valid = '0; cur_l1 = '0; cur_l2 = '0;
    ack_delay = 0; wait_cnt = 0; acks = 0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state_o, WS_IDLE);
    check("rst_outs", {busy_o, req_o, addr_o, pagefault_o, fill_set_o, fill_we_o,
                       fill_huge_o, fill_match_o, fill_trans_o}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Walker disabled by enable_i or by a zero table base.
    enable_i = 1'b0; miss_i = 1'b1; miss_vaddr_i = 32'h0040_2000;
    step(b); check("disabled_busy", b, 1'b0);
    enable_i = 1'b1; ptbr_i = '0;
    step(b); check("ptbr0_busy", b, 1'b0);
    ptbr_i = PTBR; miss_i = 1'b0;
    check("off_req", req_o, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_walk(vecs[i], -1, -1, 0);
      if (vecs[i].fault) clear_fault();
    end

    // A latched fault blocks further misses until cleared.
    run_walk(vecs[9], -1, -1, 0);
    miss_i = 1'b1; miss_vaddr_i = 32'h0040_2000;
    step(b); check("fault_miss_busy", b, 1'b0);
    step(b); check("fault_miss_req", req_o, 1'b0);
    miss_i = 1'b0;
    clear_fault();

    // Clear asserted in the very cycle the fault is raised.
    v = vecs[9];
    run_walk(v, -1, 1, 0);
    clear_fault();

    // Flush while level-1 read waits 3 cycles: request held, data discarded.
    v = '{va: 32'h0040_2000, l1: 32'h0000_0000, l2: 32'h0, valid: 2'b00, we: 2'b00, fault: 1'b0, lat: 5};
    run_walk(v, 1, -1, 3);
    check("flush_idle", dbg_state_o, WS_IDLE);

    // Flush in WRITE: no fill and the set-5 pointer stays put.
    v = '{va: 32'h0500_A000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b00, fault: 1'b0, lat: 5};
    run_walk(v, 4, -1, 0);
    v = '{va: 32'h0600_A000, l1: 32'h0100_0000, l2: 32'h0200_0500, valid: 2'b11, we: 2'b10, fault: 1'b0, lat: 6};
    run_walk(v, -1, -1, 0);

    // Asynchronous reset while the level-2 read is outstanding.
    addr_q.push_back(m_l1_addr(32'h0040_2000));
    addr_q.push_back(m_l2_addr(32'h1234_6000, 32'h0040_2000));
    cur_l1 = 32'h1234_6000; cur_l2 = 32'h5678_A5C7; cur_valid = 2'b00;
    acks = 0; wait_cnt = 0; ack_delay = 0;
    miss_i = 1'b1; miss_vaddr_i = 32'h0040_2000;
    step(b);
    miss_i = 1'b0;
    step(b);
    ack_i = 1'b0;
    check("pre_rst_state", dbg_state_o, WS_L2);
    check("pre_rst_req", req_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {req_o, busy_o, fill_we_o}, '0);
    check("async_rst_state", dbg_state_o, WS_IDLE);
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
